// File: rtl/branch_merge_requant.sv
// branch_merge_requant: merges 3x3/1x1/identity branches, accumulates
// over input channels and requantizes to int8 behind a valid/ready output.
module branch_merge_requant #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      psum_3x3,
  input  logic [15:0]      product_1x1,
  input  logic [7:0]       identity,
  input  logic [CNT_W:0]   cin_num,
  input  logic [31:0]      bias,
  input  logic             id_en,
  input  logic [CNT_W-1:0] id_ch,
  input  logic [7:0]       id_scale,
  input  logic [15:0]      mult,
  input  logic [5:0]       shift,
  input  logic             relu_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             sat_flag
);

  localparam int P_W = ACC_W + 17;
  localparam int R_W = P_W + 1;

  logic                    adv;
  logic                    accept;
  logic                    last;
  logic                    id_hit;
  logic [CNT_W-1:0]        cnt;
  logic signed [15:0]      id_prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] f_q;
  logic                    f_v;
  logic signed [P_W-1:0]   prod;
  logic signed [P_W-1:0]   m_q;
  logic                    m_v;
  logic signed [R_W-1:0]   rnd_add;
  logic signed [R_W-1:0]   rnd;
  logic signed [R_W-1:0]   r_q;
  logic                    r_v;
  logic signed [R_W-1:0]   rl;
  logic                    clip_hi;
  logic                    clip_lo;
  logic [7:0]              sat_val;

  // whole pipeline moves together; a held output freezes every stage
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign last     = ({1'b0, cnt} == (cin_num - 1'b1));

  assign id_hit  = id_en && (cnt == id_ch);
  assign id_prod = $signed(identity) * $signed(id_scale);

  // branch merge and channel accumulation
  always_comb begin
    term = {{(ACC_W-32){psum_3x3[31]}}, psum_3x3}
         + {{(ACC_W-16){product_1x1[15]}}, product_1x1};
    if (id_hit)
      term = term + {{(ACC_W-16){id_prod[15]}}, id_prod};
    base = (cnt == '0) ? {{(ACC_W-32){bias[31]}}, bias} : acc;
    sum  = base + term;
  end

  assign prod = f_q * $signed({1'b0, mult});

  // round-half-up bias ahead of the arithmetic shift
  always_comb begin
    rnd_add = '0;
    if (shift != 6'd0)
      rnd_add = R_W'(1) <<< (shift - 6'd1);
    rnd = {m_q[P_W-1], m_q} + rnd_add;
  end

  // optional relu then clamp to int8
  always_comb begin
    rl      = (relu_en && r_q < 0) ? '0 : r_q;
    clip_hi = rl > 127;
    clip_lo = rl < -128;
    sat_val = rl[7:0];
    if (clip_hi)
      sat_val = 8'h7f;
    else if (clip_lo)
      sat_val = 8'h80;
  end

  assign busy = (cnt != '0) || f_v || m_v || r_v || out_valid;

  // counter, accumulator and the F/M/R/O pipeline registers
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cnt       <= '0;
      acc       <= '0;
      f_q       <= '0;
      f_v       <= 1'b0;
      m_q       <= '0;
      m_v       <= 1'b0;
      r_q       <= '0;
      r_v       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else if (adv) begin
      if (accept) begin
        cnt <= last ? '0 : cnt + 1'b1;
        acc <= sum;
      end
      f_v <= accept && last;
      if (accept && last)
        f_q <= sum;
      m_v <= f_v;
      if (f_v)
        m_q <= prod;
      r_v <= m_v;
      if (m_v)
        r_q <= rnd >>> shift;
      out_valid <= r_v;
      if (r_v) begin
        out_data <= sat_val;
        if (clip_hi || clip_lo)
          sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_merge_requant.sv
// tb_branch_merge_requant: table vectors, corner sequences and random
// groups checked against a channel-sum reference model.
module tb_branch_merge_requant;

  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      psum_3x3;
  logic [15:0]      product_1x1;
  logic [7:0]       identity;
  logic [CNT_W:0]   cin_num;
  logic [31:0]      bias;
  logic             id_en;
  logic [CNT_W-1:0] id_ch;
  logic [7:0]       id_scale;
  logic [15:0]      mult;
  logic [5:0]       shift;
  logic             relu_en;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             busy;
  logic             sat_flag;

  branch_merge_requant dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .psum_3x3(psum_3x3), .product_1x1(product_1x1),
    .identity(identity), .cin_num(cin_num), .bias(bias),
    .id_en(id_en), .id_ch(id_ch), .id_scale(id_scale),
    .mult(mult), .shift(shift), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int cin; int b; bit ide; int ich; int isc;
    int m; int sh; bit relu;
    int ps; int pr; int idv;
    int exp_d; bit exp_s;
  } vec_t;

  vec_t vt[11];

  // reference model state
  int     m_cin, m_bias, m_ich, m_isc, m_mult, m_sh;
  bit     m_ide, m_relu;
  longint m_sum;
  int     m_ch;
  int     exp_q[$];

  function automatic int rq(longint f, int mu, int sh, bit rl);
    longint p;
    p = f * longint'(mu);
    if (sh > 0) p = p + (longint'(1) << (sh - 1));
    p = p >>> sh;
    if (rl && p < 0) p = 0;
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    return int'(p);
  endfunction

  task automatic set_cfg(int cin, int b, bit ide, int ich, int isc,
                         int mu, int sh, bit rl);
    cin_num  = (CNT_W+1)'(cin);
    bias     = b;
    id_en    = ide;
    id_ch    = CNT_W'(ich);
    id_scale = 8'(isc);
    mult     = 16'(mu);
    shift    = 6'(sh);
    relu_en  = rl;
    m_cin = cin; m_bias = b; m_ide = ide; m_ich = ich;
    m_isc = isc; m_mult = mu; m_sh = sh; m_relu = rl;
    m_ch = 0; m_sum = 0;
  endtask

  task automatic send_beat(int ps, int pr, int idv);
    bit ok;
    int tries;
    longint t;
    in_valid    = 1'b1;
    psum_3x3    = ps;
    product_1x1 = 16'(pr);
    identity    = 8'(idv);
    ok = 1'b0;
    tries = 0;
    while (!ok && tries < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!ok) begin
      chk("accept_timeout", tries, 0);
    end else begin
      t = longint'(ps) + longint'(pr);
      if (m_ide && m_ch == m_ich) t = t + longint'(idv * m_isc);
      m_sum = (m_ch == 0) ? longint'(m_bias) + t : m_sum + t;
      if (m_ch == m_cin - 1) begin
        exp_q.push_back(rq(m_sum, m_mult, m_sh, m_relu));
        m_ch = 0;
      end else begin
        m_ch++;
      end
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_done", k < 500, 1);
  endtask

  // output monitor: ordered scoreboard plus stall behaviour
  bit         mon_en = 1'b0;
  bit         was_stall = 1'b0;
  logic [7:0] held;
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        if (was_stall) chk("stall_hold", out_data, held);
        held = out_data;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          chk("extra_output", exp_q.size(), 1);
        else
          chk("sb_out", longint'($signed(out_data)), exp_q.pop_front());
      end
    end
  end

  bit rnd_rdy = 1'b0;
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    vt[0]  = '{1, 0, 0, 0, 0, 1, 0, 0, 100, 20, 0, 120, 0};
    vt[1]  = '{3, -500, 0, 0, 0, 1, 5, 0, 1000, 0, 0, 78, 0};
    vt[2]  = '{2, 0, 1, 1, 2, 1, 0, 1, 0, 0, -10, 0, 0};
    vt[3]  = '{2, 0, 1, 1, 2, 1, 0, 0, 0, 0, -10, -20, 0};
    vt[4]  = '{1, -24, 0, 0, 0, 1, 4, 0, 0, 0, 0, -1, 0};
    vt[5]  = '{1, 0, 0, 0, 0, 1, 0, 0, 40000, 0, 0, 127, 1};
    vt[6]  = '{1, 0, 0, 0, 0, 1, 0, 0, -300, 0, 0, -128, 1};
    vt[7]  = '{2, 10, 0, 0, 0, 3, 2, 0, 7, -3, 0, 14, 0};
    vt[8]  = '{1, 0, 0, 0, 0, 1, 1, 0, -7, 0, 0, -3, 0};
    vt[9]  = '{1, 0, 0, 0, 0, 40000, 20, 0, 1000, 0, 0, 38, 0};
    vt[10] = '{3, 0, 1, 0, -3, 1, 0, 0, 1, 1, 5, -9, 0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    psum_3x3 = '0; product_1x1 = '0; identity = '0;
    out_ready = 1'b1;
    set_cfg(1, 0, 0, 0, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    for (int v = 0; v < 11; v++) begin
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      set_cfg(vt[v].cin, vt[v].b, vt[v].ide, vt[v].ich, vt[v].isc,
              vt[v].m, vt[v].sh, vt[v].relu);
      for (int i = 0; i < vt[v].cin; i++) begin
        in_valid = 1'b1;
        psum_3x3 = vt[v].ps;
        product_1x1 = 16'(vt[v].pr);
        identity = 8'(vt[v].idv);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("v%0d_latency", v), lat, 3);
      chk($sformatf("v%0d_data", v), longint'($signed(out_data)), vt[v].exp_d);
      chk($sformatf("v%0d_sat", v), sat_flag, vt[v].exp_s);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy_after", v), busy, 0);
    end

    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_clears_sat", sat_flag, 0);

    mon_en = 1'b1;

    // backpressure: six single-channel pixels with a 5-cycle stall
    set_cfg(1, 0, 0, 0, 0, 1, 0, 0);
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(10 * i + 5, i, 0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset in the middle of a 4-channel group
    set_cfg(4, 7, 0, 0, 0, 1, 0, 0);
    send_beat(1000, 0, 0);
    send_beat(1000, 0, 0);
    rst_n = 1'b0;
    in_valid = 1'b1;
    psum_3x3 = 1000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    m_ch = 0;
    chk("abort_rst_busy", busy, 0);
    for (int i = 1; i <= 4; i++) send_beat(i, 0, 0);
    in_valid = 1'b0;
    drain();

    // flush together with a beat in the middle of a group
    send_beat(1000, 0, 0);
    send_beat(1000, 0, 0);
    flush = 1'b1;
    in_valid = 1'b1;
    psum_3x3 = 1000;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    m_ch = 0;
    chk("abort_flush_busy", busy, 0);
    for (int i = 1; i <= 4; i++) send_beat(2 * i, 1, 0);
    in_valid = 1'b0;
    drain();

    // randomized configurations and groups with random out_ready
    for (int c = 0; c < 12; c++) begin
      int cin;
      cin = $urandom_range(1, 5);
      set_cfg(cin, int'($urandom_range(0, 2000000)) - 1000000,
              1'($urandom_range(0, 1)), $urandom_range(0, cin - 1),
              int'($urandom_range(0, 255)) - 128,
              $urandom_range(0, 65535), $urandom_range(0, 30),
              1'($urandom_range(0, 1)));
      rnd_rdy = 1'b1;
      for (int g = 0; g < 3; g++) begin
        for (int b = 0; b < cin; b++)
          send_beat(int'($urandom_range(0, 2000000)) - 1000000,
                    int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 255)) - 128);
        if ($urandom_range(0, 1) == 1) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b0;
      drain();
      rnd_rdy = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
